// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M iterative divider.
// Holds the funct3[1:0] operation encodings, the divider FSM state enum,
// the special-case constants and small decode helpers on the op field.
package muldiv_pkg;

    // funct3[1:0] encodings of the four divide/remainder instructions
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } div_state_e;

    // Signed-overflow dividend and the all-ones divide-by-zero quotient
    localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [31:0] DIV_ALL_ONES     = 32'hFFFF_FFFF;

    // Bit 0 clear selects the signed flavours (DIV, REM)
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Bit 1 set selects the remainder flavours (REM, REMU)
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div32_sub_step.sv
// One restoring-division subtract step.
// Ports:
//   rem     in  WIDTH+1  partial remainder after the left shift
//   divisor in  WIDTH    divisor magnitude (zero-extended internally)
//   diff    out WIDTH+1  rem - {0, divisor}
//   borrow  out 1        set when divisor > rem (keep rem unchanged)
module sub_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   diff,
    output logic             borrow
);

    // One extra bit above the 33-bit difference captures the borrow out
    logic [WIDTH+1:0] full_s;

    assign full_s = {1'b0, rem} - {2'b00, divisor};
    assign diff   = full_s[WIDTH:0];
    assign borrow = full_s[WIDTH+1];

endmodule

// File: rtl/div32.sv
// Sequential restoring divider for DIV / DIVU / REM / REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish
// directly from the accept edge.
// Ports:
//   clk     in  1      rising-edge clock
//   rst     in  1      synchronous active-high reset
//   start   in  1      request, accepted only while ready=1
//   op      in  2      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   A, B    in  WIDTH  dividend / divisor, sampled on accept
//   ready   out 1      high only in IDLE
//   done    out 1      one-cycle pulse, Result valid
//   Result  out WIDTH  quotient or remainder, held until next done
module div32
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] Result
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] OVF_DIV  = WIDTH'(DIV_OVF_DIVIDEND);
    localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(DIV_ALL_ONES);

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return (~x) + ONE;
    endfunction

    div_state_e       state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] divisor_r;
    logic [1:0]       op_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic [WIDTH-1:0] result_r;
    logic             ready_r;
    logic             done_r;

    logic             accept_s;
    logic             signed_op_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] abs_a_s;
    logic [WIDTH-1:0] abs_b_s;
    logic             div_zero_s;
    logic             overflow_s;
    logic             special_s;
    logic [WIDTH-1:0] special_result_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;
    logic             borrow_s;
    logic [WIDTH-1:0] fix_result_s;

    assign accept_s    = start && (state_r == ST_IDLE);
    assign signed_op_s = op_is_signed(op);
    assign a_neg_s     = signed_op_s && A[WIDTH-1];
    assign b_neg_s     = signed_op_s && B[WIDTH-1];
    assign abs_a_s     = a_neg_s ? negate(A) : A;
    assign abs_b_s     = b_neg_s ? negate(B) : B;
    assign div_zero_s  = (B == ZERO);
    assign overflow_s  = signed_op_s && (A == OVF_DIV) && (B == ALL_ONES);
    assign special_s   = div_zero_s || overflow_s;

    // {rem, quo} shifted left by one: the quotient MSB enters the remainder
    assign shifted_s = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};

    sub_step #(.WIDTH(WIDTH)) u_sub_step (
        .rem     (shifted_s),
        .divisor (divisor_r),
        .diff    (diff_s),
        .borrow  (borrow_s)
    );

    // Special-case result chosen at accept time
    always_comb begin
        special_result_s = ZERO;
        if (div_zero_s) begin
            special_result_s = op_is_rem(op) ? A : ALL_ONES;
        end else begin
            special_result_s = op_is_rem(op) ? ZERO : OVF_DIV;
        end
    end

    // Sign fix applied to the magnitude result in FIX
    always_comb begin
        fix_result_s = ZERO;
        if (op_is_rem(op_r)) begin
            fix_result_s = neg_r_r ? negate(rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];
        end else begin
            fix_result_s = neg_q_r ? negate(quo_r) : quo_r;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = special_s ? ST_DONE : ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_FIX;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FIX:  state_next_s = ST_DONE;
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == ST_IDLE);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Operand setup, shift-subtract iteration and result load
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            rem_r     <= {(WIDTH+1){1'b0}};
            quo_r     <= ZERO;
            divisor_r <= ZERO;
            op_r      <= 2'b00;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            result_r  <= ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r      <= op;
                        neg_q_r   <= a_neg_s ^ b_neg_s;
                        neg_r_r   <= a_neg_s;
                        divisor_r <= abs_b_s;
                        quo_r     <= abs_a_s;
                        rem_r     <= {(WIDTH+1){1'b0}};
                        cnt_r     <= {CNT_W{1'b0}};
                        if (special_s) begin
                            result_r <= special_result_s;
                        end
                    end
                end
                ST_RUN: begin
                    // Restore on borrow: keep the shifted remainder
                    rem_r <= borrow_s ? shifted_s : diff_s;
                    quo_r <= {quo_r[WIDTH-2:0], ~borrow_s};
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                ST_FIX: begin
                    result_r <= fix_result_s;
                end
                default: begin
                end
            endcase
        end
    end

    assign ready  = ready_r;
    assign done   = done_r;
    assign Result = result_r;

endmodule
